if_fetch_queue: RTL and testbench

- In-order instruction fetch queue between the instruction fetch stage and the decode stage.
- Allocates an entry carrying pc/pc_next when a fetch is issued to instruction memory, and fills it with the instruction word when imem responds.
- Presents completed entries to decode through a valid/ready handshake.
- Decouples memory latency and decode stalls from fetch, and discards wrong-path responses after a redirect flush.

---
 rtl/if_fetch_queue.sv | 134 +++++++++++++
 tb/tb_if_fetch_queue.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// In-order fetch queue between IF and decode: entries allocated at fetch issue, filled on imem response.
// Optional IFQ_BYPASS_EN: present a response to decode in the same cycle it lands on an unfilled head.
module if_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_flush,
  input  logic        i_req_valid,
  input  logic [31:0] i_req_pc,
  input  logic [31:0] i_req_pc_next,
  input  logic        i_resp_valid,
  input  logic [31:0] i_resp_rdata,
  input  logic        i_ready,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_next,
  output logic        o_full,
  output logic        o_empty,
  output logic        o_resp_err
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0][31:0] pc_q, pc_d, pcn_q, pcn_d, instr_q, instr_d;
  logic [DEPTH-1:0]       filled_q, filled_d;
  logic [PTR_W-1:0]       head_q, head_d, alloc_q, alloc_d, fill_q, fill_d;
  logic [CNT_W-1:0]       count_q, count_d, pend_q, pend_d, drop_q, drop_d;
  logic                   err_q, err_d;
  logic                   do_alloc, head_rdy, byp, pop;

  assign o_full     = (count_q == CNT_W'(DEPTH));
  assign o_empty    = (count_q == '0);
  assign o_resp_err = err_q;

  always_comb begin
    head_rdy = !o_empty && filled_q[head_q] && !i_flush;
`ifdef IFQ_BYPASS_EN
    // An unfilled head is always the fill target, so the response belongs to it.
    byp = !o_empty && !filled_q[head_q] && (drop_q == '0) && !i_flush && i_resp_valid;
`else
    byp = 1'b0;
`endif
    o_valid   = head_rdy || byp;
    o_instr   = byp ? i_resp_rdata : (head_rdy ? instr_q[head_q] : 32'h0);
    o_pc      = o_valid ? pc_q[head_q]  : 32'h0;
    o_pc_next = o_valid ? pcn_q[head_q] : 32'h0;
    pop       = o_valid && i_ready;
  end

  always_comb begin
    pc_d     = pc_q;
    pcn_d    = pcn_q;
    instr_d  = instr_q;
    filled_d = filled_q;
    head_d   = head_q;
    alloc_d  = alloc_q;
    fill_d   = fill_q;
    count_d  = count_q;
    pend_d   = pend_q;
    drop_d   = drop_q;
    err_d    = err_q;
    do_alloc = i_req_valid && !o_full;

    if (i_flush) begin
      // Every still-unfilled entry has a response on its way; a flush-cycle response consumes one.
      filled_d = '0;
      head_d   = alloc_q;
      fill_d   = alloc_q;
      count_d  = '0;
      pend_d   = '0;
      drop_d   = (i_resp_valid && pend_q != '0) ? pend_q - CNT_W'(1) : pend_q;
    end else begin
      if (i_resp_valid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CNT_W'(1);
        end else if (pend_q != '0) begin
          if (!(byp && i_ready)) begin
            instr_d[fill_q]  = i_resp_rdata;
            filled_d[fill_q] = 1'b1;
          end
          fill_d = fill_q + PTR_W'(1);
          pend_d = pend_d - CNT_W'(1);
        end else begin
          err_d = 1'b1;
        end
      end
      if (pop) begin
        filled_d[head_q] = 1'b0;
        head_d  = head_q + PTR_W'(1);
        count_d = count_d - CNT_W'(1);
      end
    end

    if (do_alloc) begin
      pc_d[alloc_q]     = i_req_pc;
      pcn_d[alloc_q]    = i_req_pc_next;
      filled_d[alloc_q] = 1'b0;
      alloc_d = alloc_q + PTR_W'(1);
      count_d = count_d + CNT_W'(1);
      pend_d  = pend_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filled_q <= '0;
      head_q   <= '0;
      alloc_q  <= '0;
      fill_q   <= '0;
      count_q  <= '0;
      pend_q   <= '0;
      drop_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      filled_q <= filled_d;
      head_q   <= head_d;
      alloc_q  <= alloc_d;
      fill_q   <= fill_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      drop_q   <= drop_d;
      err_q    <= err_d;
    end
  end

  // Payload storage is qualified by the filled bits, so it needs no reset.
  always_ff @(posedge clk) begin
    pc_q    <= pc_d;
    pcn_q   <= pcn_d;
    instr_q <= instr_d;
  end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue (default build): vector table for basic flow/error/reset, scoreboard for queued sequences.
module tb_if_fetch_queue;
  logic        clk = 1'b0;
  logic        rst_n, i_flush, i_req_valid, i_resp_valid, i_ready;
  logic [31:0] i_req_pc, i_req_pc_next, i_resp_rdata;
  logic        o_valid, o_full, o_empty, o_resp_err;
  logic [31:0] o_instr, o_pc, o_pc_next;

  always #5 clk = ~clk;

  if_fetch_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_flush(i_flush),
    .i_req_valid(i_req_valid), .i_req_pc(i_req_pc), .i_req_pc_next(i_req_pc_next),
    .i_resp_valid(i_resp_valid), .i_resp_rdata(i_resp_rdata), .i_ready(i_ready),
    .o_valid(o_valid), .o_instr(o_instr), .o_pc(o_pc), .o_pc_next(o_pc_next),
    .o_full(o_full), .o_empty(o_empty), .o_resp_err(o_resp_err)
  );

  typedef struct { logic [31:0] pc, pcn, instr; } ent_t;
  typedef struct {
    logic rs, fl, rq; logic [31:0] pc, pcn; logic rv; logic [31:0] rd; logic rdy;
    logic ev; logic [31:0] ei, ep, en; logic ef, ee, er;
  } vec_t;

  int total = 0, bad = 0, pops = 0;
  ent_t sb[$];
  logic sb_on = 1'b0;
  logic s_valid, s_full, s_empty, s_err;
  logic [31:0] s_instr, s_pc, s_pcn;
  vec_t tv[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Drive one cycle, sample at the falling edge, retire pops against the scoreboard.
  task automatic cyc(input logic rs, fl, rq, input logic [31:0] pc, pcn,
                     input logic rv, input logic [31:0] rd, input logic rdy);
    ent_t e;
    rst_n = rs; i_flush = fl; i_req_valid = rq; i_req_pc = pc; i_req_pc_next = pcn;
    i_resp_valid = rv; i_resp_rdata = rd; i_ready = rdy;
    @(negedge clk);
    s_valid = o_valid; s_full = o_full; s_empty = o_empty; s_err = o_resp_err;
    s_instr = o_instr; s_pc = o_pc; s_pcn = o_pc_next;
    if (sb_on && rs && o_valid && rdy) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_pop: got pc %h want no entry", o_pc);
      end else begin
        e = sb.pop_front();
        chk("pop_pc", o_pc, e.pc);
        chk("pop_pc_next", o_pc_next, e.pcn);
        chk("pop_instr", o_instr, e.instr);
        pops++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, rdy);
  endtask
  task automatic req(input logic [31:0] pc, input logic rdy);
    cyc(1'b1, 1'b0, 1'b1, pc, pc + 32'd4, 1'b0, 32'h0, rdy);
  endtask
  task automatic resp(input logic [31:0] d, input logic rdy);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, d, rdy);
  endtask

  function automatic vec_t v(input logic rs, fl, rq, input logic [31:0] pc, pcn,
                             input logic rv, input logic [31:0] rd, input logic rdy, ev,
                             input logic [31:0] ei, ep, en, input logic ef, ee, er);
    vec_t t;
    t.rs = rs; t.fl = fl; t.rq = rq; t.pc = pc; t.pcn = pcn; t.rv = rv; t.rd = rd; t.rdy = rdy;
    t.ev = ev; t.ei = ei; t.ep = ep; t.en = en; t.ef = ef; t.ee = ee; t.er = er;
    return t;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    // Expected outputs are those seen during the row's cycle, before its clock edge.
    tv[0] = v(1,0,0,0,0,0,0,0,                      0,0,0,0,0,1,0);
    tv[1] = v(1,0,1,32'h60000000,32'h60000004,0,0,1, 0,0,0,0,0,1,0);
    tv[2] = v(1,0,0,0,0,1,32'h00000013,1,            0,0,0,0,0,0,0);
    tv[3] = v(1,0,0,0,0,0,0,1,                      1,32'h13,32'h60000000,32'h60000004,0,0,0);
    tv[4] = v(1,0,0,0,0,0,0,1,                      0,0,0,0,0,1,0);
    tv[5] = v(1,0,0,0,0,1,32'hDEADBEEF,1,            0,0,0,0,0,1,0);
    tv[6] = v(1,0,0,0,0,0,0,1,                      0,0,0,0,0,1,1);
    tv[7] = v(0,0,0,0,0,0,0,0,                      0,0,0,0,0,1,1);
    tv[8] = v(1,0,0,0,0,0,0,0,                      0,0,0,0,0,1,0);

    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);

    for (int i = 0; i < 9; i++) begin
      cyc(tv[i].rs, tv[i].fl, tv[i].rq, tv[i].pc, tv[i].pcn, tv[i].rv, tv[i].rd, tv[i].rdy);
      chk($sformatf("r%0d_valid", i), {31'h0, s_valid}, {31'h0, tv[i].ev});
      chk($sformatf("r%0d_instr", i), s_instr, tv[i].ei);
      chk($sformatf("r%0d_pc", i), s_pc, tv[i].ep);
      chk($sformatf("r%0d_pc_next", i), s_pcn, tv[i].en);
      chk($sformatf("r%0d_full", i), {31'h0, s_full}, {31'h0, tv[i].ef});
      chk($sformatf("r%0d_empty", i), {31'h0, s_empty}, {31'h0, tv[i].ee});
      chk($sformatf("r%0d_err", i), {31'h0, s_err}, {31'h0, tv[i].er});
    end
    sb_on = 1'b1;

    // Fill to capacity under backpressure, then drain in order.
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{32'h60000000 + 32'(4*i), 32'h60000004 + 32'(4*i), 32'hA0000000 + 32'(i)});
      req(32'h60000000 + 32'(4*i), 1'b0);
    end
    for (int i = 0; i < 4; i++) resp(32'hA0000000 + 32'(i), 1'b0);
    req(32'h60000010, 1'b0);
    chk("full_flag", {31'h0, s_full}, 32'h1);
    chk("full_head_valid", {31'h0, s_valid}, 32'h1);
    pops = 0;
    for (int k = 0; k < 10 && sb.size() != 0; k++) idle(1'b1);
    chk("full_drain_left", sb.size(), 0);
    chk("full_pops", pops, 4);
    idle(1'b1);
    chk("full_empty_after", {31'h0, s_empty}, 32'h1);
    chk("full_no_extra", {31'h0, s_valid}, 32'h0);

    // Flush with three fetches in flight; target request allocates in the flush cycle.
    for (int i = 0; i < 3; i++) req(32'h60000040 + 32'(4*i), 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 32'h60000100, 32'h60000104, 1'b0, 32'h0, 1'b1);
    sb.push_back('{32'h60000100, 32'h60000104, 32'hBEEF0100});
    pops = 0;
    for (int i = 0; i < 3; i++) begin
      resp(32'h11110000 + 32'(i), 1'b1);
      chk("flush_drop_valid", {31'h0, s_valid}, 32'h0);
    end
    resp(32'hBEEF0100, 1'b1);
    chk("flush_fill_latency", {31'h0, s_valid}, 32'h0);
    idle(1'b1);
    idle(1'b1);
    chk("flush_pops", pops, 1);
    chk("flush_left", sb.size(), 0);

    // Flush coinciding with a response: that response counts against the drop.
    for (int i = 0; i < 2; i++) req(32'h60000180 + 32'(4*i), 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'hBADBAD00, 1'b0);
    sb.push_back('{32'h60000200, 32'h60000204, 32'hC0DE0200});
    pops = 0;
    cyc(1'b1, 1'b0, 1'b1, 32'h60000200, 32'h60000204, 1'b1, 32'h22222222, 1'b1);
    resp(32'hC0DE0200, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("samecyc_pops", pops, 1);
    chk("samecyc_left", sb.size(), 0);

    // Ten single-entry round trips walk every pointer across the wrap.
    pops = 0;
    for (int i = 0; i < 10; i++) begin
      sb.push_back('{32'h60001000 + 32'(4*i), 32'h60001004 + 32'(4*i), 32'h30000000 + 32'(i)});
      req(32'h60001000 + 32'(4*i), 1'b1);
      resp(32'h30000000 + 32'(i), 1'b1);
      idle(1'b1);
    end
    chk("wrap_pops", pops, 10);
    chk("wrap_left", sb.size(), 0);

    // Sticky error with entries held, then reset mid-operation.
    req(32'h60002000, 1'b0);
    req(32'h60002004, 1'b0);
    resp(32'h44440000, 1'b0);
    resp(32'h44440001, 1'b0);
    resp(32'h55555555, 1'b0);
    idle(1'b0);
    chk("err_set", {31'h0, s_err}, 32'h1);
    chk("err_hold_valid", {31'h0, s_valid}, 32'h1);
    idle(1'b0);
    chk("err_sticky", {31'h0, s_err}, 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    idle(1'b0);
    chk("rst_valid", {31'h0, s_valid}, 32'h0);
    chk("rst_empty", {31'h0, s_empty}, 32'h1);
    chk("rst_err", {31'h0, s_err}, 32'h0);
    chk("rst_instr", s_instr, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
